// File: rtl/crc_frame_engine.sv
// crc_frame_engine: frame-aware, parameterised CRC generator.
// A valid/ready word stream delimited by sof/eof is folded into a CRC
// register; the finished CRC is presented on a held m_valid/m_ready handshake.
// Optional build macro CRC_FRAME_CHECK_EN adds m_crc_ok, a residue compare
// of the raw register at eof for receive-side checking of frames that carry
// their own CRC.
module crc_frame_engine #(
    parameter int          DATA_W      = 16,
    parameter int          CRC_W       = 32,
    parameter logic [31:0] POLY        = 32'h04C11DB7,
    parameter logic [31:0] INIT        = 32'h00000000,
    parameter logic [31:0] XOROUT      = 32'h00000000,
    parameter int          REFLECT_IN  = 0,
    parameter int          REFLECT_OUT = 0
`ifdef CRC_FRAME_CHECK_EN
    ,
    parameter logic [31:0] RESIDUE     = 32'h00000000
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    input  logic              s_eof,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CRC_W-1:0]  m_crc,
    output logic              err_proto,
    input  logic              err_clr,
`ifdef CRC_FRAME_CHECK_EN
    output logic              m_crc_ok,
`endif
    output logic [15:0]       frame_cnt
);

    localparam logic [CRC_W-1:0] POLY_C   = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] INIT_C   = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOROUT_C = XOROUT[CRC_W-1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CRC_W-1:0]  crc_r;
    logic [CRC_W-1:0]  crc_base;
    logic [CRC_W-1:0]  crc_next;
    logic              beat;
    logic              load;
    logic              fin;
    logic              err_set;
    logic              done_ack;

    // Fold one whole input word into the register, MSB first, in one cycle.
    function automatic logic [CRC_W-1:0] crc_word(
        input logic [CRC_W-1:0]  r_in,
        input logic [DATA_W-1:0] d_in
    );
        logic [CRC_W-1:0]  r;
        logic [DATA_W-1:0] d;
        logic              fb;
        r = r_in;
        for (int i = 0; i < DATA_W; i++)
            d[i] = (REFLECT_IN != 0) ? d_in[DATA_W-1-i] : d_in[i];
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ d[i];
            r  = (r << 1) ^ (fb ? POLY_C : {CRC_W{1'b0}});
        end
        return r;
    endfunction

    // Output transform applied once, when the frame closes.
    function automatic logic [CRC_W-1:0] crc_final(input logic [CRC_W-1:0] r_in);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++)
            r[i] = (REFLECT_OUT != 0) ? r_in[CRC_W-1-i] : r_in[i];
        return r ^ XOROUT_C;
    endfunction

    // Handshake outputs are pure decodes of the registered state.
    assign s_ready = (state != DONE);
    assign m_valid = (state == DONE);
    assign beat    = s_valid & s_ready;

    // A sof word always starts from INIT, whether opening or restarting a frame.
    assign crc_base = s_sof ? INIT_C : crc_r;
    assign crc_next = crc_word(crc_base, s_data);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        err_set   = 1'b0;
        done_ack  = 1'b0;
        case (state)
            IDLE: begin
                if (beat) begin
                    if (s_sof) begin
                        load      = 1'b1;
                        state_nxt = s_eof ? DONE : RUN;
                    end else begin
                        err_set   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (beat) begin
                    load    = 1'b1;
                    err_set = s_sof;
                    if (s_eof) state_nxt = DONE;
                end
            end
            DONE: begin
                if (m_ready) begin
                    done_ack  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fin = load & s_eof;

    // CRC register, held result, sticky error and frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_r     <= INIT_C;
            m_crc     <= '0;
            err_proto <= 1'b0;
            frame_cnt <= 16'h0000;
        end else begin
            if (load)     crc_r     <= crc_next;
            if (fin)      m_crc     <= crc_final(crc_next);
            if (done_ack) frame_cnt <= frame_cnt + 16'h0001;
            if (err_clr)      err_proto <= 1'b0;
            else if (err_set) err_proto <= 1'b1;
        end
    end

`ifdef CRC_FRAME_CHECK_EN
    localparam logic [CRC_W-1:0] RESIDUE_C = RESIDUE[CRC_W-1:0];

    // Residue compare on the raw register, captured alongside m_crc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      m_crc_ok <= 1'b0;
        else if (fin) m_crc_ok <= (crc_next == RESIDUE_C);
    end
`endif

endmodule

// File: tb/tb_crc_frame_engine.sv
// Self-checking bench for crc_frame_engine. Five differently configured
// instances share one input stream; each result is compared to a bit-serial
// whole-message reference model parameterised per instance.
module tb_crc_frame_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_sof = 1'b0;
    logic        s_eof = 1'b0;
    logic        m_ready = 1'b0;
    logic        err_clr = 1'b0;

    logic        s_ready_a, s_ready_b, s_ready_c, s_ready_d, s_ready_e;
    logic        m_valid_a, m_valid_b, m_valid_c, m_valid_d, m_valid_e;
    logic        err_a, err_b, err_c, err_d, err_e;
    logic [15:0] cnt_a, cnt_b, cnt_c, cnt_d, cnt_e;
    logic [31:0] crc_a, crc_b, crc_c, crc_e;
    logic [15:0] crc_d;
`ifdef CRC_FRAME_CHECK_EN
    logic        ok_a, ok_b, ok_c, ok_d, ok_e;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] exp_cnt = '0;

    // Model configuration, index: 0=A 1=B 2=C 3=D 4=E
    int          dw_t [5] = '{16, 8, 8, 12, 8};
    int          cw_t [5] = '{32, 32, 32, 16, 32};
    logic [31:0] pl_t [5] = '{32'h04C11DB7, 32'h04C11DB7, 32'h04C11DB7, 32'h00001021, 32'h04C11DB7};
    logic [31:0] in_t [5] = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFFFFF};
    logic [31:0] xo_t [5] = '{32'h0, 32'hFFFFFFFF, 32'h0, 32'h00005A5A, 32'hFFFFFFFF};
    bit          ri_t [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit          ro_t [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    logic [31:0] crc_out [5];
    assign crc_out[0] = crc_a;
    assign crc_out[1] = crc_b;
    assign crc_out[2] = crc_c;
    assign crc_out[3] = {16'h0, crc_d};
    assign crc_out[4] = crc_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc_frame_engine u_a (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
        .s_sof(s_sof), .s_eof(s_eof), .m_valid(m_valid_a), .m_ready(m_ready), .m_crc(crc_a),
        .err_proto(err_a), .err_clr(err_clr),
`ifdef CRC_FRAME_CHECK_EN
        .m_crc_ok(ok_a),
`endif
        .frame_cnt(cnt_a));

    crc_frame_engine #(.DATA_W(8), .INIT(32'hFFFFFFFF), .XOROUT(32'hFFFFFFFF),
                       .REFLECT_IN(1), .REFLECT_OUT(1)) u_b (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data[7:0]),
        .s_sof(s_sof), .s_eof(s_eof), .m_valid(m_valid_b), .m_ready(m_ready), .m_crc(crc_b),
        .err_proto(err_b), .err_clr(err_clr),
`ifdef CRC_FRAME_CHECK_EN
        .m_crc_ok(ok_b),
`endif
        .frame_cnt(cnt_b));

    crc_frame_engine #(.DATA_W(8), .INIT(32'hFFFFFFFF), .XOROUT(32'h0)) u_c (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_c), .s_data(s_data[7:0]),
        .s_sof(s_sof), .s_eof(s_eof), .m_valid(m_valid_c), .m_ready(m_ready), .m_crc(crc_c),
        .err_proto(err_c), .err_clr(err_clr),
`ifdef CRC_FRAME_CHECK_EN
        .m_crc_ok(ok_c),
`endif
        .frame_cnt(cnt_c));

    crc_frame_engine #(.DATA_W(12), .CRC_W(16), .POLY(32'h1021), .INIT(32'hFFFF),
                       .XOROUT(32'h5A5A), .REFLECT_IN(1), .REFLECT_OUT(0)) u_d (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_d), .s_data(s_data[11:0]),
        .s_sof(s_sof), .s_eof(s_eof), .m_valid(m_valid_d), .m_ready(m_ready), .m_crc(crc_d),
        .err_proto(err_d), .err_clr(err_clr),
`ifdef CRC_FRAME_CHECK_EN
        .m_crc_ok(ok_d),
`endif
        .frame_cnt(cnt_d));

    crc_frame_engine #(.DATA_W(8), .INIT(32'hFFFFFFFF), .XOROUT(32'hFFFFFFFF)) u_e (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_e), .s_data(s_data[7:0]),
        .s_sof(s_sof), .s_eof(s_eof), .m_valid(m_valid_e), .m_ready(m_ready), .m_crc(crc_e),
        .err_proto(err_e), .err_clr(err_clr),
`ifdef CRC_FRAME_CHECK_EN
        .m_crc_ok(ok_e),
`endif
        .frame_cnt(cnt_e));

    // Reference: flatten the frame into one bit sequence, then divide serially.
    function automatic logic [31:0] model_crc(input int k, input logic [15:0] w[$]);
        bit          bits[$];
        logic [63:0] mask;
        logic [31:0] r, o;
        bit          fb;
        int          cw;
        cw   = cw_t[k];
        mask = (64'h1 << cw) - 64'h1;
        foreach (w[j])
            for (int b = 0; b < dw_t[k]; b++)
                bits.push_back(ri_t[k] ? w[j][b] : w[j][dw_t[k]-1-b]);
        r = in_t[k] & mask[31:0];
        foreach (bits[j]) begin
            fb = r[cw-1] ^ bits[j];
            r  = ((r << 1) ^ (fb ? pl_t[k] : 32'h0)) & mask[31:0];
        end
        o = r;
        if (ro_t[k]) begin
            o = '0;
            for (int b = 0; b < cw; b++) o[b] = r[cw-1-b];
        end
        return (o ^ xo_t[k]) & mask[31:0];
    endfunction

    task automatic idle_cycles(input int n);
        repeat (n) begin
            s_valid = 1'b0;
            s_data  = 16'($urandom);
            s_sof   = 1'($urandom);
            s_eof   = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic beat(input logic [15:0] d, input logic sof, input logic eof);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_sof = sof; s_eof = eof;
        while (!s_ready_a && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL beat_timeout: s_ready=%b required 1", s_ready_a);
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_data = 16'($urandom); s_sof = 1'($urandom); s_eof = 1'($urandom);
    endtask

    task automatic send_frame(input logic [15:0] w[$], input bit gaps);
        foreach (w[i]) begin
            if (gaps) idle_cycles($urandom_range(0, 2));
            beat(w[i], i == 0, i == w.size() - 1);
        end
    endtask

    task automatic check_result(input logic [15:0] w[$], input string tag);
        logic [31:0] e;
        checks++;
        if ({m_valid_a, m_valid_b, m_valid_c, m_valid_d, m_valid_e} !== 5'h1F) begin
            errors++;
            $display("FAIL %s_valid: m_valid=%b required 11111", tag,
                     {m_valid_a, m_valid_b, m_valid_c, m_valid_d, m_valid_e});
        end
        for (int k = 0; k < 5; k++) begin
            e = model_crc(k, w);
            checks++;
            if (crc_out[k] !== e) begin
                errors++;
                $display("FAIL %s_crc[%0d]: got %h required %h", tag, k, crc_out[k], e);
            end
        end
    endtask

    task automatic consume(input bit rand_ready);
        logic [31:0] held;
        int          n = 0;
        bit          done = 0;
        held = crc_a;
        while (!done && n < 100) begin
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1; n++;
            if (m_ready) done = 1;
            else begin
                checks++;
                if (m_valid_a !== 1'b1 || s_ready_a !== 1'b0 || crc_a !== held) begin
                    errors++;
                    $display("FAIL hold: v=%b rdy=%b crc=%h required 1 0 %h",
                             m_valid_a, s_ready_a, crc_a, held);
                end
            end
        end
        m_ready = 1'b0;
        exp_cnt++;
        checks++;
        if (!done || cnt_a !== exp_cnt || cnt_d !== exp_cnt || m_valid_a !== 1'b0 ||
            s_ready_a !== 1'b1 || crc_a !== held) begin
            errors++;
            $display("FAIL consume: cnt=%0d v=%b rdy=%b crc=%h required %0d 0 1 %h",
                     cnt_a, m_valid_a, s_ready_a, crc_a, exp_cnt, held);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2 rst = 1'b1; #4 rst = 1'b0;
        @(posedge clk); #1;
        exp_cnt = '0;
    endtask

    task automatic test_reset();
        checks++;
        if (s_ready_a !== 1'b1 || m_valid_a !== 1'b0 || crc_a !== 32'h0 ||
            err_a !== 1'b0 || cnt_a !== 16'h0 || crc_d !== 16'h0) begin
            errors++;
            $display("FAIL reset: rdy=%b v=%b crc=%h err=%b cnt=%h required 1 0 0 0 0",
                     s_ready_a, m_valid_a, crc_a, err_a, cnt_a);
        end
`ifdef CRC_FRAME_CHECK_EN
        checks++;
        if (ok_c !== 1'b0) begin errors++; $display("FAIL reset_ok: got %b required 0", ok_c); end
`endif
    endtask

    task automatic test_known_answer();
        logic [15:0] w[$];
        for (int i = 0; i < 9; i++) w.push_back(16'h0031 + 16'(i));
        send_frame(w, 0);
        check_result(w, "kat");
        checks++;
        if (crc_b !== 32'hCBF43926 || crc_c !== 32'h0376E6E7 || crc_e !== 32'hFC891918) begin
            errors++;
            $display("FAIL kat_const: got %h %h %h required cbf43926 0376e6e7 fc891918",
                     crc_b, crc_c, crc_e);
        end
        consume(0);
    endtask

    task automatic test_hold();
        logic [15:0] w[$];
        logic [31:0] held;
        w.push_back(16'h0000);
        send_frame(w, 0);
        check_result(w, "single");
        checks++;
        if (crc_a !== 32'h0) begin errors++; $display("FAIL single_zero: got %h required 0", crc_a); end
        held = crc_a;
        m_ready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            checks++;
            if (s_ready_a !== 1'b0 || m_valid_a !== 1'b1 || crc_a !== held) begin
                errors++;
                $display("FAIL stall: rdy=%b v=%b crc=%h required 0 1 %h", s_ready_a, m_valid_a, crc_a, held);
            end
        end
        consume(0);
    endtask

    task automatic test_proto();
        logic [15:0] w1[$], w2[$];
        beat(16'h1234, 1'b0, 1'b0);
        checks++;
        if (err_a !== 1'b1 || m_valid_a !== 1'b0) begin
            errors++; $display("FAIL no_sof: err=%b v=%b required 1 0", err_a, m_valid_a);
        end
        idle_cycles(2);
        checks++;
        if (m_valid_a !== 1'b0 || s_ready_a !== 1'b1) begin
            errors++; $display("FAIL no_sof_idle: v=%b rdy=%b required 0 1", m_valid_a, s_ready_a);
        end
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
        checks++;
        if (err_a !== 1'b0) begin errors++; $display("FAIL err_clr: got %b required 0", err_a); end
        // clear must win over a same-cycle error
        err_clr = 1'b1;
        beat(16'h5555, 1'b0, 1'b1);
        err_clr = 1'b0;
        checks++;
        if (err_a !== 1'b0) begin errors++; $display("FAIL clr_wins: got %b required 0", err_a); end
        for (int i = 0; i < 3; i++) begin
            w1.push_back(16'($urandom));
            w2.push_back(16'($urandom));
        end
        beat(w1[0], 1'b1, 1'b0);
        beat(w1[1], 1'b0, 1'b0);
        checks++;
        if (m_valid_a !== 1'b0 || err_a !== 1'b0) begin
            errors++; $display("FAIL partial: v=%b err=%b required 0 0", m_valid_a, err_a);
        end
        send_frame(w2, 1);
        checks++;
        if (err_a !== 1'b1) begin errors++; $display("FAIL restart_err: got %b required 1", err_a); end
        check_result(w2, "restart");
        consume(1);
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
    endtask

    task automatic test_midreset();
        logic [15:0] w[$];
        beat(16'hABCD, 1'b1, 1'b0);
        beat(16'h0F0F, 1'b0, 1'b0);
        pulse_reset();
        checks++;
        if (cnt_a !== 16'h0 || m_valid_a !== 1'b0 || s_ready_a !== 1'b1 || crc_a !== 32'h0) begin
            errors++;
            $display("FAIL midreset: cnt=%h v=%b rdy=%b crc=%h required 0 0 1 0",
                     cnt_a, m_valid_a, s_ready_a, crc_a);
        end
        for (int i = 0; i < 4; i++) w.push_back(16'($urandom));
        send_frame(w, 1);
        check_result(w, "post_reset");
        consume(1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] w[$];
        int start, expect_cyc;
        m_ready = 1'b1;
        expect_cyc = 0;
        start = cyc;
        for (int f = 0; f < 8; f++) begin
            w.delete();
            for (int i = 0; i < int'($urandom_range(1, 4)); i++) w.push_back(16'($urandom));
            expect_cyc += w.size() + 1;
            send_frame(w, 0);
            check_result(w, "b2b");
            exp_cnt++;
        end
        @(posedge clk); #1;
        m_ready = 1'b0;
        checks++;
        if (cyc - start != expect_cyc || cnt_a !== exp_cnt) begin
            errors++;
            $display("FAIL b2b_rate: cycles=%0d cnt=%0d required %0d %0d",
                     cyc - start, cnt_a, expect_cyc, exp_cnt);
        end
    endtask

    task automatic test_random();
        logic [15:0] w[$];
        int n;
        pulse_reset();
        for (int f = 0; f < 1000; f++) begin
            w.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) w.push_back(16'($urandom));
            send_frame(w, 1);
            check_result(w, "rand");
            consume(1);
        end
        checks++;
        if (cnt_a !== 16'd1000) begin
            errors++; $display("FAIL rand_cnt: got %0d required 1000", cnt_a);
        end
    endtask

`ifdef CRC_FRAME_CHECK_EN
    task automatic test_check();
        logic [15:0] w[$];
        for (int i = 0; i < 9; i++) w.push_back(16'h0031 + 16'(i));
        w.push_back(16'h03); w.push_back(16'h76); w.push_back(16'hE6); w.push_back(16'hE7);
        send_frame(w, 0);
        checks++;
        if (ok_c !== 1'b1) begin errors++; $display("FAIL residue_good: got %b required 1", ok_c); end
        consume(0);
        w[4] = w[4] ^ 16'h0010;
        send_frame(w, 1);
        checks++;
        if (ok_c !== 1'b0) begin errors++; $display("FAIL residue_bad: got %b required 0", ok_c); end
        consume(0);
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_known_answer();
        test_hold();
        test_proto();
        test_midreset();
        test_back_to_back();
`ifdef CRC_FRAME_CHECK_EN
        test_check();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
